// File: rtl/key_cmd_conditioner_pkg.sv
// Package key_pkg: shared types and sizing helpers for the key conditioner.
//   key_state_e : per-channel debounce / hold state
//   cnt_width() : bits needed to count 0 .. n-1
//   max2()      : larger of two ints
package key_pkg;

  typedef enum logic [2:0] {
    K_IDLE,
    K_DEB_PRESS,
    K_HELD,
    K_LONG,
    K_DEB_REL
  } key_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_cmd_conditioner_if.sv
// key_cmd_conditioner_if: raw pushbuttons in, conditioned key strobes out.
//   i_key_n   : raw active-low buttons (asynchronous to the clock)
//   o_level   : debounced state, 1 = held
//   o_press   : 1-cycle accepted press (also auto-repeat when enabled)
//   o_release : 1-cycle accepted release
//   o_long    : 1-cycle long-press
// master = button/board side, slave = conditioner.
interface key_cmd_conditioner_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] i_key_n;
  logic [NUM_KEYS-1:0] o_level;
  logic [NUM_KEYS-1:0] o_press;
  logic [NUM_KEYS-1:0] o_release;
  logic [NUM_KEYS-1:0] o_long;

  modport master (output i_key_n, input o_level, o_press, o_release, o_long);
  modport slave  (input i_key_n, output o_level, o_press, o_release, o_long);
endinterface

// File: rtl/key_cmd_conditioner_channel.sv
// key_channel: one key lane -- 2-flop synchroniser, debounce/hold FSM, counter.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_key_n   : raw active-low button
//   o_level   : debounced level
//   o_press / o_release / o_long : registered 1-cycle strobes
// Optional: KEY_AUTOREPEAT_EN adds a repeat timer in K_LONG that re-pulses
// o_press every REPEAT_CYCLES while the key stays down.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 3000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("key_channel: DEBOUNCE_CYCLES/LONG_CYCLES must be >= 2, REPEAT_CYCLES >= 1");
  end

  localparam int CW = cnt_width(max2(DEBOUNCE_CYCLES, LONG_CYCLES));
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  // Sync flops reset to 1 (released) so reset never looks like a press.
  logic sync1, sync2, s;
  assign s = ~sync2;

  key_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ret_long, ret_long_nxt;   // release began from K_LONG
  logic          level_nxt, press_nxt, release_nxt, long_nxt;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt, rpt_nxt;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      state     <= K_IDLE;
      cnt       <= '0;
      ret_long  <= 1'b0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      sync1     <= i_key_n;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ret_long  <= ret_long_nxt;
      o_level   <= level_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      o_long    <= long_nxt;
`ifdef KEY_AUTOREPEAT_EN
      rpt       <= rpt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ret_long_nxt = ret_long;
    level_nxt    = o_level;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rpt_nxt      = rpt;
`endif
    case (state)
      K_IDLE: begin
        if (s) begin
          state_nxt = K_DEB_PRESS;
          cnt_nxt   = CW'(1);
        end
      end
      K_DEB_PRESS: begin
        if (!s) begin
          state_nxt = K_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = K_HELD;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      K_HELD: begin
        if (!s) begin
          state_nxt    = K_DEB_REL;
          cnt_nxt      = CW'(1);
          ret_long_nxt = 1'b0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = K_LONG;
          long_nxt  = 1'b1;
          cnt_nxt   = '0;
`ifdef KEY_AUTOREPEAT_EN
          rpt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      K_LONG: begin
        if (!s) begin
          state_nxt    = K_DEB_REL;
          cnt_nxt      = CW'(1);
          ret_long_nxt = 1'b1;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rpt == RPT_LAST) begin
          press_nxt = 1'b1;
          rpt_nxt   = '0;
        end else begin
          rpt_nxt = rpt + RW'(1);
        end
`endif
      end
      K_DEB_REL: begin
        if (s) begin
          // Release was a glitch: resume, long timer starts over.
          state_nxt = ret_long ? K_LONG : K_HELD;
          cnt_nxt   = '0;
`ifdef KEY_AUTOREPEAT_EN
          rpt_nxt   = '0;
`endif
        end else if (cnt == DEB_LAST) begin
          state_nxt   = K_IDLE;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = K_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_cmd_conditioner.sv
// key_cmd_conditioner: turns bouncing active-low DE2 pushbuttons into clean
// command strobes for the recorder/player control FSM
// (key 0 = record, key 1 = play/pause, key 2 = stop).
// Ports:
//   i_clk, i_rst (async, active-high)
//   kif (slave) : i_key_n in; o_level, o_press, o_release, o_long out
// Optional: KEY_AUTOREPEAT_EN enables o_press auto-repeat after a long press.
// Channels are independent; coincident pulses are passed through unprioritised.
module key_cmd_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 3000000
) (
  input logic                   i_clk,
  input logic                   i_rst,
  key_cmd_conditioner_if.slave  kif
);

  logic [NUM_KEYS-1:0] level, press, rls, lng;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_key_n   (kif.i_key_n[g]),
      .o_level   (level[g]),
      .o_press   (press[g]),
      .o_release (rls[g]),
      .o_long    (lng[g])
    );
  end

  assign kif.o_level   = level;
  assign kif.o_press   = press;
  assign kif.o_release = rls;
  assign kif.o_long    = lng;

endmodule
